// File: rtl/player_collision_resolver.sv
// Per-frame player/obstacle overlap resolver: counts overlap pixels per player edge and
// publishes blocked-edge flags, an obstacle hit mask and a new-collision pulse each frame.
module player_collision_resolver #(
    parameter int unsigned NUM_OBST = 3,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned MIN_HITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                startOfFrame,
    input  logic                playerDR,
    input  logic [3:0]          hitEdgeCode,
    input  logic [NUM_OBST-1:0] obstDR,
    output logic                blockedTop,
    output logic                blockedBottom,
    output logic                blockedLeft,
    output logic                blockedRight,
    output logic [NUM_OBST-1:0] hitObstMask,
    output logic                collisionPulse
);

    typedef enum logic [1:0] {
        StWaitFrame,
        StAccum,
        StPublish
    } state_e;

    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MinHits = CNT_W'(MIN_HITS);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    // Edge vectors are indexed by edge code: 0=bottom, 1=left, 2=right, 3=top.
    state_e                   state_q, state_d;
    logic [3:0][CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_OBST-1:0]      acc_mask_q, acc_mask_d;
    logic [3:0]               cand_q, cand_d;
    logic [NUM_OBST-1:0]      cand_mask_q, cand_mask_d;
    logic [3:0]               blocked_q, blocked_d;
    logic [NUM_OBST-1:0]      hit_mask_q, hit_mask_d;
    logic                     pulse_q, pulse_d;

    logic                     hit;
    logic [3:0]               edge_sel;
    logic [3:0][CNT_W-1:0]    cnt_inc;
    logic [3:0][CNT_W-1:0]    cnt_fresh;
    logic [3:0]               meets;
    logic [NUM_OBST-1:0]      mask_in;

    assign hit     = playerDR & (|obstDR);
    assign mask_in = playerDR ? obstDR : '0;

    always_comb begin
        edge_sel = '0;
        if (hitEdgeCode < 4'd4) begin
            edge_sel[hitEdgeCode[1:0]] = 1'b1;
        end
    end

    // Continuing count, fresh-frame count (boundary pixel belongs to the new frame), threshold.
    always_comb begin
        cnt_inc   = cnt_q;
        cnt_fresh = '0;
        meets     = '0;
        for (int e = 0; e < 4; e++) begin
            if (hit && edge_sel[e] && (cnt_q[e] != CntMax)) begin
                cnt_inc[e] = cnt_q[e] + CntOne;
            end
            if (hit && edge_sel[e]) begin
                cnt_fresh[e] = CntOne;
            end
            meets[e] = (cnt_q[e] >= MinHits);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_mask_d  = acc_mask_q;
        cand_d      = cand_q;
        cand_mask_d = cand_mask_q;
        blocked_d   = blocked_q;
        hit_mask_d  = hit_mask_q;
        pulse_d     = 1'b0;

        case (state_q)
            StWaitFrame: begin
                if (startOfFrame) begin
                    cnt_d      = cnt_fresh;
                    acc_mask_d = mask_in;
                    state_d    = StAccum;
                end
            end
            StAccum: begin
                if (startOfFrame) begin
                    cand_d      = meets;
                    cand_mask_d = acc_mask_q;
                    cnt_d       = cnt_fresh;
                    acc_mask_d  = mask_in;
                    state_d     = StPublish;
                end else begin
                    cnt_d      = cnt_inc;
                    acc_mask_d = acc_mask_q | mask_in;
                end
            end
            StPublish: begin
                // A frame start here would be a 1-pixel frame; it is dropped and counting goes on.
                blocked_d  = cand_q;
                hit_mask_d = cand_mask_q;
                pulse_d    = |(cand_q & ~blocked_q);
                cnt_d      = cnt_inc;
                acc_mask_d = acc_mask_q | mask_in;
                state_d    = StAccum;
            end
            default: begin
                state_d = StWaitFrame;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StWaitFrame;
            cnt_q       <= '0;
            acc_mask_q  <= '0;
            cand_q      <= '0;
            cand_mask_q <= '0;
            blocked_q   <= '0;
            hit_mask_q  <= '0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_mask_q  <= acc_mask_d;
            cand_q      <= cand_d;
            cand_mask_q <= cand_mask_d;
            blocked_q   <= blocked_d;
            hit_mask_q  <= hit_mask_d;
            pulse_q     <= pulse_d;
        end
    end

    assign blockedBottom  = blocked_q[0];
    assign blockedLeft    = blocked_q[1];
    assign blockedRight   = blocked_q[2];
    assign blockedTop     = blocked_q[3];
    assign hitObstMask    = hit_mask_q;
    assign collisionPulse = pulse_q;

endmodule
